fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_out_buffer.sv | 44 ++++
 rtl/fetch_controller.sv | 99 +++++++++
 tb/tb_fetch_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, word size and reset address for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_out_buffer.sv
// fetch_out_buffer: IF/ID output register plus one-entry skid register
module fetch_out_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic        load,
    input  logic        unload,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_word,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        slot_free
);
    logic [31:0] skid_pc, skid_word;
    assign slot_free = !valid || !freeze;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc <= '0;
            instruction <= '0;
            skid_pc <= '0;
            skid_word <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            skid_pc <= '0;
            skid_word <= '0;
        end else if (load && slot_free) begin
            valid <= 1'b1;
            pc <= load_pc;
            instruction <= load_word;
        end else if (load) begin
            skid_pc <= load_pc;
            skid_word <= load_word;
        end else if (unload) begin
            valid <= 1'b1;
            pc <= skid_pc;
            instruction <= skid_word;
        end else if (slot_free) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch FSM with redirect squash; FETCH_PERF_EN adds stall_count
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);
    state_t state, state_n;
    logic [31:0] pc, pc_n, redirect, redirect_n, pc_inc;
    logic load, unload, slot_free;
    assign pc_inc = pc + WORD_BYTES;
    assign mem_addr = pc;
    assign mem_req = state != HOLD;
    always_comb begin
        state_n = state;
        pc_n = pc;
        redirect_n = redirect;
        load = 1'b0;
        unload = 1'b0;
        case (state)
            FETCH:
                if (branch_taken) begin
                    if (mem_ready) pc_n = branch_address;
                    else begin
                        redirect_n = branch_address;
                        state_n = SQUASH;
                    end
                end else if (mem_ready) begin
                    pc_n = pc_inc;
                    load = 1'b1;
                    state_n = slot_free ? FETCH : HOLD;
                end
            HOLD:
                if (branch_taken) begin
                    pc_n = branch_address;
                    state_n = FETCH;
                end else if (slot_free) begin
                    unload = 1'b1;
                    state_n = FETCH;
                end
            SQUASH: begin
                redirect_n = branch_taken ? branch_address : redirect;
                if (mem_ready) begin
                    pc_n = branch_taken ? branch_address : redirect;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            redirect <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            redirect <= redirect_n;
        end
    end
    fetch_out_buffer u_buf (
        .clk(clk),
        .rst(rst),
        .flush(branch_taken),
        .freeze(freeze),
        .load(load),
        .unload(unload),
        .load_pc(pc_inc),
        .load_word(mem_rdata),
        .valid(if_valid),
        .pc(if_pc),
        .instruction(if_instruction),
        .slot_free(slot_free)
    );
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) stall_count <= '0;
        else if (((mem_req && !mem_ready) || state == HOLD) && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: vector table, corner sequences and randomized queue-model check
module tb_fetch_controller;
    localparam logic [31:0] RPC = 32'h100;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
    logic [31:0] branch_address = '0, mem_rdata = '0;
    logic mem_req, if_valid;
    logic [31:0] mem_addr, if_pc, if_instruction;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_count;
`endif
    int n_cmp = 0, n_bad = 0;

    fetch_controller #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instruction(if_instruction)
`ifdef FETCH_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: presented words form a queue of at most two (front shown, second waiting)
    logic [31:0] m_pc, m_redir, m_stall;
    bit m_sq;
    logic [31:0] q_pc[$], q_in[$];

    task automatic model_step(input bit r, f, b, input logic [31:0] ba, input bit rdy, input logic [31:0] rd);
        bit req;
        if (r) begin
            m_pc = RPC; m_redir = '0; m_sq = 0; m_stall = '0;
            q_pc.delete(); q_in.delete();
            return;
        end
        req = q_pc.size() < 2;
        if (((req && !rdy) || !req) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (b) begin
            if (m_sq) begin
                if (rdy) begin m_pc = ba; m_sq = 0; end
                else m_redir = ba;
            end else if (!req || rdy) m_pc = ba;
            else begin m_sq = 1; m_redir = ba; end
            q_pc.delete(); q_in.delete();
        end else begin
            if (q_pc.size() > 0 && !f) begin
                void'(q_pc.pop_front()); void'(q_in.pop_front());
            end
            if (m_sq) begin
                if (rdy) begin m_pc = m_redir; m_sq = 0; end
            end else if (req && rdy) begin
                q_pc.push_back(m_pc + 32'd4); q_in.push_back(rd);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit f, b, input logic [31:0] ba, input bit rdy, input logic [31:0] rd);
        freeze = f; branch_taken = b; branch_address = ba; mem_ready = rdy; mem_rdata = rd;
        model_step(rst, f, b, ba, rdy, rd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic chk_model();
        chk("mdl_req", {31'd0, mem_req}, {31'd0, q_pc.size() < 2});
        chk("mdl_addr", mem_addr, m_pc);
        chk("mdl_valid", {31'd0, if_valid}, {31'd0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            chk("mdl_pc", if_pc, q_pc[0]);
            chk("mdl_instr", if_instruction, q_in[0]);
        end
`ifdef FETCH_PERF_EN
        chk("mdl_stall", stall_count, m_stall);
`endif
    endtask

    typedef struct {
        bit f, b; logic [31:0] ba; bit rdy; logic [31:0] rd;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc, e_instr;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 0, 0, 1, 32'hA0, 1, 32'h104, 1, 32'h104, 32'hA0};
        tbl[1] = '{0, 0, 0, 1, 32'hA1, 1, 32'h108, 1, 32'h108, 32'hA1};
        tbl[2] = '{0, 0, 0, 1, 32'hA2, 1, 32'h10C, 1, 32'h10C, 32'hA2};
        tbl[3] = '{0, 1, 32'h40, 1, 32'hDEAD, 1, 32'h40, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 32'hB0, 1, 32'h44, 1, 32'h44, 32'hB0};
        tbl[5] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h44, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 32'h44, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 32'hBAD, 1, 32'hFFFF_FFFC, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 1, 32'hC0, 1, 32'h0, 1, 32'h0, 32'hC0};
        tbl[9] = '{0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0};

        do_reset();
        chk("rst_req", {31'd0, mem_req}, 32'd1);
        chk("rst_addr", mem_addr, RPC);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instruction, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].f, tbl[i].b, tbl[i].ba, tbl[i].rdy, tbl[i].rd);
            chk($sformatf("tbl%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), if_instruction, tbl[i].e_instr);
            end
        end

        // freeze for three cycles with a word presented: held, one word skidded, no request
        do_reset();
        step(0, 0, 0, 1, 32'hF0);
        chk("frz_w0", if_instruction, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 32'hF1 + i);
            chk("frz_hold_valid", {31'd0, if_valid}, 32'd1);
            chk("frz_hold_instr", if_instruction, 32'hF0);
            chk("frz_hold_req", {31'd0, mem_req}, 32'd0);
            chk("frz_hold_addr", mem_addr, 32'h108);
        end
        step(0, 0, 0, 1, 32'hEE);
        chk("frz_w1_instr", if_instruction, 32'hF1);
        chk("frz_w1_pc", if_pc, 32'h108);
        chk("frz_w1_req", {31'd0, mem_req}, 32'd1);
        step(0, 0, 0, 1, 32'hF2);
        chk("frz_w2_instr", if_instruction, 32'hF2);
        chk("frz_w2_pc", if_pc, 32'h10C);

        // two wait states with a branch in the first wait cycle
        do_reset();
        step(0, 1, 32'h200, 0, 0);
        chk("sq_addr0", mem_addr, RPC);
        chk("sq_req0", {31'd0, mem_req}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("sq_valid1", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h0BAD);
        chk("sq_addr2", mem_addr, 32'h200);
        chk("sq_valid2", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h600D);
        chk("sq_instr3", if_instruction, 32'h600D);
        chk("sq_pc3", if_pc, 32'h204);

        // reset while squashing, with branch and freeze also asserted
        do_reset();
        step(0, 1, 32'h200, 0, 0);
        rst = 1'b1;
        step(1, 1, 32'h300, 0, 0);
        rst = 1'b0;
        chk("rsq_addr", mem_addr, RPC);
        chk("rsq_valid", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rsq_stall", stall_count, 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] ba;
            chk_model();
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, ba,
                 $urandom_range(0, 9) < 6, $urandom);
        end
        rst = 1'b0;
        chk_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
